conv_window_scanner: RTL and testbench
======================================

Name: conv_window_scanner

Overview:
- Address sequencer for stride-1, unpadded ("valid") 2D convolution over an image stored row-major in feature memory.
- For each output position it emits, in row-major order, the KxK input-pixel addresses of that window.
- Each address is presented on a valid/ready stream to the downstream pixel-fetch stage.
- Replaces the hand-wired chain of COUNTER_POS instances in the convolution datapath, with position tracking and handshake built in.

Parameters:
ADDR_WIDTH, 16, width of memory addresses; all address arithmetic is modulo 2^ADDR_WIDTH
DIM_WIDTH, 10, width of image width/height and row/col outputs
KERNEL, 3, kernel side K; legal range 1..15

Ports:
SCAN_Clk  in  1  clock, rising edge
SCAN_Rst  in  1  asynchronous reset, active-high
SCAN_Start  in  1  start pulse; sampled only in IDLE
SCAN_Img_Width  in  DIM_WIDTH  image width W; latched on accepted start
SCAN_Img_Height  in  DIM_WIDTH  image height H; latched on accepted start
SCAN_Base_Addr  in  ADDR_WIDTH  address of pixel (0,0); latched on accepted start
SCAN_Ready  in  1  downstream ready
SCAN_Valid  out  1  SCAN_Addr is valid
SCAN_Addr  out  ADDR_WIDTH  pixel address
SCAN_Win_Last  out  1  current beat is the last (K*K-th) beat of its window
SCAN_Out_Row  out  DIM_WIDTH  output-row index r of the current window
SCAN_Out_Col  out  DIM_WIDTH  output-col index c of the current window
SCAN_Busy  out  1  high in SCAN and DONE states
SCAN_Done  out  1  one-cycle pulse at end of job
SCAN_Err  out  1  one-cycle pulse with SCAN_Done when W<K or H<K

Behaviour:
- Reset (asynchronous, active-high, any time including mid-job): state IDLE; every output 0; all internal counters and latched operands 0. The job is discarded. No handshake completes in the reset cycle.
- States: IDLE, SCAN, DONE.
- IDLE:
  - SCAN_Start=1 latches W, H and base.
  - If W<K or H<K, go to DONE with an error flag set.
  - Otherwise go to SCAN.
- SCAN:
  - SCAN_Valid=1 from the first SCAN cycle. The first address appears on the cycle after start is accepted (latency 1).
  - Beat address = base + (r+kr)*W + (c+kc), with kr,kc in 0..K-1. kc is the innermost index, then kr, then c, then r.
  - Implementation is incremental adders only; no multiplier. Keep a window-base pointer and a row pointer; advance each by 1, by W, or by W-K+1 as required.
  - Advance to the next beat only on the cycle Valid&&Ready. While Ready=0, SCAN_Addr, SCAN_Win_Last, SCAN_Out_Row and SCAN_Out_Col hold stable.
  - SCAN_Win_Last=1 when kr=kc=K-1.
  - SCAN_Out_Row and SCAN_Out_Col report r and c of the current beat.
  - Index ranges: r in 0..H-K, c in 0..W-K.
  - Total beats per job = (H-K+1)*(W-K+1)*K*K.
  - The handshake on the final beat (r=H-K, c=W-K, kr=kc=K-1) moves to DONE. SCAN_Valid drops to 0 the next cycle, with no bubble before it and no extra beat.
- DONE:
  - Lasts exactly one cycle.
  - SCAN_Done=1; SCAN_Err=1 if the error flag is set.
  - Valid=0.
  - Then IDLE; Busy=0 from the IDLE cycle onward.
- SCAN_Start is ignored in SCAN and DONE. Start held high across DONE->IDLE launches a new job in that IDLE cycle.
- Input changes on W/H/base after start have no effect on the running job.
- Address overflow wraps modulo 2^ADDR_WIDTH and raises no error.
- K=1: each window is one beat, and Win_Last=1 on every beat.
- W=K and H=K: exactly one window of K*K beats.
- Ready may toggle every cycle; each Valid&&Ready edge consumes exactly one beat.

Test Plan:
- Basic scan, K=3, W=4, H=4, base=0x0100, Ready=1 -> 36 beats.
  - Window 0: 0x100,101,102,104,105,106,108,109,10A, with Win_Last only on 0x10A.
  - Window 1 starts at 0x101 (row 0, col 1); window 2 at 0x104 (row 1, col 0); window 3 at 0x105.
  - Done pulse on the cycle after the last beat; Busy low one cycle later.
- Backpressure: same job with Ready as a random ~50% pattern -> identical 36-address sequence; outputs stable on every Ready=0 cycle; still exactly 36 handshakes.
- Error: W=2, H=5, K=3, start -> no Valid ever; Done=1 and Err=1 on the cycle after start; return to IDLE.
- Wrap: base=0xFFFE, W=H=3, K=3 -> addresses 0xFFFE,0xFFFF,0x0000,0x0001,0x0002,0x0003,0x0004,0x0005,0x0006; single window; Done pulse.
- Reset mid-job: assert SCAN_Rst during beat 10 of the basic scan -> all outputs 0 immediately (asynchronous). A new start after release runs from window 0 with the correct sequence.
- Start while busy and back-to-back jobs:
  - Pulse Start during SCAN with different W/H -> ignored; the original sequence is unchanged.
  - Start held through DONE -> second job begins from IDLE; its first beat appears 1 cycle later.

Source files
------------

// File: rtl/conv_window_scanner.sv
// rtl/conv_window_scanner.sv - KxK window address sequencer for stride-1 valid 2D convolution
module conv_window_scanner #(
  parameter int ADDR_WIDTH = 16,
  parameter int DIM_WIDTH  = 10,
  parameter int KERNEL     = 3
) (
  input  logic                  SCAN_Clk,
  input  logic                  SCAN_Rst,
  input  logic                  SCAN_Start,
  input  logic [DIM_WIDTH-1:0]  SCAN_Img_Width,
  input  logic [DIM_WIDTH-1:0]  SCAN_Img_Height,
  input  logic [ADDR_WIDTH-1:0] SCAN_Base_Addr,
  input  logic                  SCAN_Ready,
  output logic                  SCAN_Valid,
  output logic [ADDR_WIDTH-1:0] SCAN_Addr,
  output logic                  SCAN_Win_Last,
  output logic [DIM_WIDTH-1:0]  SCAN_Out_Row,
  output logic [DIM_WIDTH-1:0]  SCAN_Out_Col,
  output logic                  SCAN_Busy,
  output logic                  SCAN_Done,
  output logic                  SCAN_Err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0]            K_LAST = 4'(KERNEL - 1);
  localparam logic [DIM_WIDTH-1:0]  K_DIM  = DIM_WIDTH'(KERNEL);
  localparam logic [ADDR_WIDTH-1:0] K_ADDR = ADDR_WIDTH'(KERNEL);
  localparam logic [ADDR_WIDTH-1:0] K_M1_A = ADDR_WIDTH'(KERNEL - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE_A  = ADDR_WIDTH'(1);
  localparam logic [DIM_WIDTH-1:0]  ONE_D  = DIM_WIDTH'(1);

  logic [1:0]            state;
  logic [DIM_WIDTH-1:0]  w_q;
  logic [DIM_WIDTH-1:0]  h_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] win_ptr;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            kr;
  logic [3:0]            kc;
  logic [DIM_WIDTH-1:0]  row_q;
  logic [DIM_WIDTH-1:0]  col_q;

  logic [ADDR_WIDTH-1:0] row_step;
  logic                  kc_end;
  logic                  kr_end;
  logic                  col_end;
  logic                  row_end;
  logic                  start_err;

  // Stepping from the last pixel of one kernel row to the first of the next is W-K+1
  assign row_step  = ADDR_WIDTH'(w_q) - K_M1_A;
  assign kc_end    = (kc == K_LAST);
  assign kr_end    = (kr == K_LAST);
  assign col_end   = (col_q == w_q - K_DIM);
  assign row_end   = (row_q == h_q - K_DIM);
  assign start_err = (SCAN_Img_Width < K_DIM) || (SCAN_Img_Height < K_DIM);

  always_ff @(posedge SCAN_Clk or posedge SCAN_Rst) begin
    if (SCAN_Rst) begin
      state   <= ST_IDLE;
      w_q     <= '0;
      h_q     <= '0;
      err_q   <= 1'b0;
      win_ptr <= '0;
      addr_q  <= '0;
      kr      <= '0;
      kc      <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (SCAN_Start) begin
            w_q     <= SCAN_Img_Width;
            h_q     <= SCAN_Img_Height;
            win_ptr <= SCAN_Base_Addr;
            addr_q  <= SCAN_Base_Addr;
            kr      <= '0;
            kc      <= '0;
            row_q   <= '0;
            col_q   <= '0;
            err_q   <= start_err;
            state   <= start_err ? ST_DONE : ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (SCAN_Ready) begin
            if (!kc_end) begin
              kc     <= kc + 4'd1;
              addr_q <= addr_q + ONE_A;
            end else if (!kr_end) begin
              kc     <= '0;
              kr     <= kr + 4'd1;
              addr_q <= addr_q + row_step;
            end else begin
              kc <= '0;
              kr <= '0;
              // Window origin moves right by 1, or from (r, W-K) to (r+1, 0) which is +K
              if (!col_end) begin
                col_q   <= col_q + ONE_D;
                win_ptr <= win_ptr + ONE_A;
                addr_q  <= win_ptr + ONE_A;
              end else if (!row_end) begin
                col_q   <= '0;
                row_q   <= row_q + ONE_D;
                win_ptr <= win_ptr + K_ADDR;
                addr_q  <= win_ptr + K_ADDR;
              end else begin
                state <= ST_DONE;
              end
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          err_q <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign SCAN_Valid    = (state == ST_SCAN);
  assign SCAN_Win_Last = SCAN_Valid && kr_end && kc_end;
  assign SCAN_Addr     = addr_q;
  assign SCAN_Out_Row  = row_q;
  assign SCAN_Out_Col  = col_q;
  assign SCAN_Busy     = (state != ST_IDLE);
  assign SCAN_Done     = (state == ST_DONE);
  assign SCAN_Err      = SCAN_Done && err_q;

endmodule

// File: tb/tb_conv_window_scanner.sv
// tb/tb_conv_window_scanner.sv - scoreboard bench for conv_window_scanner
module tb_conv_window_scanner;

  localparam int AW = 16;
  localparam int DW = 10;
  localparam int K  = 3;

  logic          SCAN_Clk = 1'b0;
  logic          SCAN_Rst = 1'b1;
  logic          SCAN_Start = 1'b0;
  logic [DW-1:0] SCAN_Img_Width = '0;
  logic [DW-1:0] SCAN_Img_Height = '0;
  logic [AW-1:0] SCAN_Base_Addr = '0;
  logic          SCAN_Ready = 1'b1;
  logic          SCAN_Valid;
  logic [AW-1:0] SCAN_Addr;
  logic          SCAN_Win_Last;
  logic [DW-1:0] SCAN_Out_Row;
  logic [DW-1:0] SCAN_Out_Col;
  logic          SCAN_Busy;
  logic          SCAN_Done;
  logic          SCAN_Err;

  conv_window_scanner #(.ADDR_WIDTH(AW), .DIM_WIDTH(DW), .KERNEL(K)) dut (
    .SCAN_Clk(SCAN_Clk), .SCAN_Rst(SCAN_Rst), .SCAN_Start(SCAN_Start),
    .SCAN_Img_Width(SCAN_Img_Width), .SCAN_Img_Height(SCAN_Img_Height),
    .SCAN_Base_Addr(SCAN_Base_Addr), .SCAN_Ready(SCAN_Ready),
    .SCAN_Valid(SCAN_Valid), .SCAN_Addr(SCAN_Addr), .SCAN_Win_Last(SCAN_Win_Last),
    .SCAN_Out_Row(SCAN_Out_Row), .SCAN_Out_Col(SCAN_Out_Col),
    .SCAN_Busy(SCAN_Busy), .SCAN_Done(SCAN_Done), .SCAN_Err(SCAN_Err)
  );

  always #5 SCAN_Clk = ~SCAN_Clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] row;
    logic [DW-1:0] col;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    hs_count = 0;
  int    exp_beats = 0;
  bit    mon_en = 1'b0;
  bit    rdy_rand = 1'b0;
  bit    exp_done_next = 1'b0;
  bit    prev_stall = 1'b0;
  logic [AW+2*DW+1:0] prev_hold = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference addresses use direct multiplication, truncated to the address width
  task automatic push_job(input int w, input int h, input int base);
    exp_beats = 0;
    for (int r = 0; r <= h - K; r++)
      for (int c = 0; c <= w - K; c++)
        for (int kr = 0; kr < K; kr++)
          for (int kc = 0; kc < K; kc++) begin
            beat_t b;
            b.addr = AW'(base + (r + kr) * w + c + kc);
            b.row  = DW'(r);
            b.col  = DW'(c);
            b.last = (kr == K - 1) && (kc == K - 1);
            exp_q.push_back(b);
            exp_beats++;
          end
  endtask

  initial forever begin
    @(posedge SCAN_Clk);
    #1 SCAN_Ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial forever begin
    @(negedge SCAN_Clk);
    if (mon_en) begin
      if (prev_stall)
        chk("hold", {SCAN_Valid, SCAN_Addr, SCAN_Win_Last, SCAN_Out_Row, SCAN_Out_Col}, 64'(prev_hold));
      if (exp_done_next) begin
        chk("done_after_last", SCAN_Done, 1'b1);
        exp_done_next = 1'b0;
      end
      if (SCAN_Valid && SCAN_Ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", SCAN_Valid, 1'b0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("addr", SCAN_Addr, e.addr);
          chk("win_last", SCAN_Win_Last, e.last);
          chk("row", SCAN_Out_Row, e.row);
          chk("col", SCAN_Out_Col, e.col);
          hs_count++;
          if (exp_q.size() == 0) exp_done_next = 1'b1;
        end
      end
      prev_stall = SCAN_Valid && !SCAN_Ready;
      prev_hold  = {SCAN_Valid, SCAN_Addr, SCAN_Win_Last, SCAN_Out_Row, SCAN_Out_Col};
    end
  end

  task automatic step();
    @(negedge SCAN_Clk);
    #1;
  endtask

  task automatic start_job(input int w, input int h, input int base, input bit hold);
    SCAN_Img_Width  = DW'(w);
    SCAN_Img_Height = DW'(h);
    SCAN_Base_Addr  = AW'(base);
    SCAN_Start      = 1'b1;
    hs_count        = 0;
    push_job(w, h, base);
    @(posedge SCAN_Clk);
    #1 if (!hold) SCAN_Start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 3000; i++) begin
      step();
      if (SCAN_Done) break;
    end
    chk(tag, SCAN_Done, 1'b1);
  endtask

  task automatic check_idle(input string tag);
    step();
    chk(tag, {SCAN_Busy, SCAN_Valid, SCAN_Done}, 3'b000);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    step();
    chk("reset_outs", {SCAN_Valid, SCAN_Addr, SCAN_Win_Last, SCAN_Out_Row, SCAN_Out_Col,
                       SCAN_Busy, SCAN_Done, SCAN_Err}, 64'd0);
    SCAN_Rst = 1'b0;
    mon_en = 1'b1;
    step();

    // Basic scan
    start_job(4, 4, 'h100, 1'b0);
    step();
    chk("first_valid", SCAN_Valid, 1'b1);
    wait_done("basic_done");
    chk("basic_err", SCAN_Err, 1'b0);
    chk("basic_beats", hs_count, exp_beats);
    check_idle("basic_idle");

    // Backpressure
    rdy_rand = 1'b1;
    start_job(4, 4, 'h100, 1'b0);
    wait_done("bp_done");
    chk("bp_beats", hs_count, exp_beats);
    rdy_rand = 1'b0;
    check_idle("bp_idle");

    // Error: W<K
    start_job(2, 5, 'h100, 1'b0);
    step();
    chk("err_done", {SCAN_Done, SCAN_Err, SCAN_Valid}, 3'b110);
    check_idle("err_idle");

    // Address wrap
    start_job(3, 3, 'hFFFE, 1'b0);
    wait_done("wrap_done");
    chk("wrap_beats", hs_count, exp_beats);
    check_idle("wrap_idle");

    // Reset mid-job during beat 10
    start_job(4, 4, 'h100, 1'b0);
    for (int i = 0; i < 200; i++) begin
      step();
      if (hs_count >= 10) break;
    end
    chk("reach_beat10", hs_count, 10);
    SCAN_Rst = 1'b1;
    #1;
    chk("midjob_reset", {SCAN_Valid, SCAN_Addr, SCAN_Win_Last, SCAN_Out_Row, SCAN_Out_Col,
                         SCAN_Busy, SCAN_Done, SCAN_Err}, 64'd0);
    mon_en = 1'b0;
    exp_q.delete();
    exp_done_next = 1'b0;
    prev_stall = 1'b0;
    step();
    SCAN_Rst = 1'b0;
    mon_en = 1'b1;
    step();
    start_job(4, 4, 'h100, 1'b0);
    wait_done("post_reset_done");
    chk("post_reset_beats", hs_count, exp_beats);
    check_idle("post_reset_idle");

    // Start pulsed while busy is ignored
    start_job(4, 4, 'h100, 1'b0);
    repeat (5) step();
    SCAN_Img_Width  = DW'(5);
    SCAN_Img_Height = DW'(6);
    SCAN_Base_Addr  = AW'('h300);
    SCAN_Start      = 1'b1;
    step();
    SCAN_Start = 1'b0;
    wait_done("busy_start_done");
    chk("busy_start_beats", hs_count, exp_beats);
    check_idle("busy_start_idle");

    // Back-to-back: Start held through DONE, operand changes mid-job ignored
    start_job(3, 3, 'h200, 1'b1);
    step();
    chk("b2b_a_first", SCAN_Valid, 1'b1);
    SCAN_Img_Width  = DW'(4);
    SCAN_Img_Height = DW'(3);
    SCAN_Base_Addr  = AW'('h400);
    wait_done("b2b_a_done");
    chk("b2b_a_beats", hs_count, exp_beats);
    hs_count = 0;
    push_job(4, 3, 'h400);
    step();
    chk("b2b_idle", {SCAN_Busy, SCAN_Valid}, 2'b00);
    @(posedge SCAN_Clk);
    #1 SCAN_Start = 1'b0;
    step();
    chk("b2b_b_first", SCAN_Valid, 1'b1);
    wait_done("b2b_b_done");
    chk("b2b_b_beats", hs_count, exp_beats);
    check_idle("b2b_b_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
